signed_divider_seq: RTL and testbench

SIGNED_DIVIDER_SEQ -- requirements
Module: signed_divider_seq

---
 rtl/signed_divider_seq.sv | 136 +++++++++++++
 tb/tb_signed_divider_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider_seq.sv
// Sequential restoring divider, signed or unsigned per operation, one quotient bit per cycle.
// Operands are reduced to magnitudes at accept and the signs are applied in a final fix-up cycle.
module signed_divider_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] pr;
  logic [WIDTH-1:0]   dvs_mag;
  logic               q_neg, r_neg, dbz_l, ovf_l;

  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  logic [WIDTH:0]     upper;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] pr_step;
  logic [WIDTH-1:0]   q_mag, r_mag;
  logic               dvd_neg, dvs_neg;

  assign dvd_neg = signed_mode & dividend[WIDTH-1];
  assign dvs_neg = signed_mode & divisor[WIDTH-1];

  // Negating MIN yields MIN again, which read as unsigned is the correct magnitude.
  assign dvd_abs = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign dvs_abs = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;

  assign q_mag = pr[WIDTH-1:0];
  assign r_mag = pr[2*WIDTH-1:WIDTH];

  // Upper half of {pr, 0} is the trial remainder; the subtract result always fits in WIDTH bits.
  always_comb begin
    upper = pr[2*WIDTH-1:WIDTH-1];
    diff  = upper[WIDTH-1:0] - dvs_mag;
    if (upper >= {1'b0, dvs_mag}) begin
      pr_step = {diff, pr[WIDTH-2:0], 1'b1};
    end else begin
      pr_step = {upper[WIDTH-1:0], pr[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (count == CW'(1)) state_next = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      pr          <= '0;
      dvs_mag     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz_l       <= 1'b0;
      ovf_l       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pr      <= {{WIDTH{1'b0}}, dvd_abs};
            dvs_mag <= dvs_abs;
            q_neg   <= dvd_neg ^ dvs_neg;
            r_neg   <= dvd_neg;
            dbz_l   <= (divisor == '0);
            ovf_l   <= signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       && (divisor == '1);
            count   <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          pr    <= pr_step;
          count <= count - CW'(1);
        end
        S_FIX: begin
          // A zero divisor leaves the dividend magnitude in the remainder, so re-signing restores it.
          quotient    <= dbz_l ? '1 : (q_neg ? (~q_mag + WIDTH'(1)) : q_mag);
          remainder   <= r_neg ? (~r_mag + WIDTH'(1)) : r_mag;
          div_by_zero <= dbz_l;
          overflow    <= ovf_l;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Self-checking bench for signed_divider_seq (WIDTH=8): directed corner cases plus
// randomized operations checked against an integer-arithmetic reference.
module tb_signed_divider_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  signed_divider_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .signed_mode(signed_mode),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result packed as {overflow, div_by_zero, quotient, remainder}.
  function automatic logic [17:0] ref_div(input bit m, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, q, r;
    if (b == 8'h00) return {1'b0, 1'b1, 8'hFF, a};
    if (m) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) return {1'b1, 1'b0, 8'h80, 8'h00};
      q = sa / sb;
      r = sa % sb;
    end else begin
      sa = int'(a);
      sb = int'(b);
      q = sa / sb;
      r = sa % sb;
    end
    return {1'b0, 1'b0, q[7:0], r[7:0]};
  endfunction

  task automatic launch(input bit m, input logic [7:0] a, input logic [7:0] b, input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    signed_mode = m;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    dividend    = 8'($urandom);
    divisor     = 8'($urandom);
    signed_mode = 1'($urandom);
  endtask

  // Counts edges after the accepting edge until done; optionally pokes start while busy.
  task automatic wait_done(input bit inject, output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (inject && cyc <= int'(W)) begin
        start       = 1'($urandom);
        dividend    = 8'($urandom);
        divisor     = 8'($urandom);
        signed_mode = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [17:0] exp);
    chk({tag, " quotient"}, 32'(quotient), 32'(exp[15:8]));
    chk({tag, " remainder"}, 32'(remainder), 32'(exp[7:0]));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp[16]));
    chk({tag, " overflow"}, 32'(overflow), 32'(exp[17]));
  endtask

  task automatic finish_op(input string tag, input logic [17:0] exp, input bit inject);
    int cyc;
    bit bok;
    wait_done(inject, cyc, bok);
    chk({tag, " latency"}, 32'(cyc), 32'(W + 1));
    chk({tag, " busy_during"}, 32'(bok), 32'd1);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check_result(tag, exp);
    @(posedge clk);
    #1;
    chk({tag, " done_width"}, 32'(done), 32'd0);
    chk({tag, " quotient_held"}, 32'(quotient), 32'(exp[15:8]));
  endtask

  task automatic run_op(input string tag, input bit m, input logic [7:0] a, input logic [7:0] b,
                        input logic [17:0] exp, input bit inject);
    launch(m, a, b, 1'b0);
    finish_op(tag, exp, inject);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom % 8)
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h00;
      3: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int cyc;
    bit bok;
    bit saw_done;
    logic [7:0] ra, rb;
    bit rm;

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset flags", 32'({div_by_zero, overflow}), 32'd0);

    // Reset released and start asserted together: first edge with rst_n high accepts.
    launch(1'b0, 8'd100, 8'd7, 1'b1);
    finish_op("u100/7", {2'b00, 8'd14, 8'd2}, 1'b0);

    run_op("s-7/2", 1'b1, 8'hF9, 8'h02, {2'b00, 8'hFD, 8'hFF}, 1'b0);
    run_op("s7/-2", 1'b1, 8'h07, 8'hFE, {2'b00, 8'hFD, 8'h01}, 1'b1);
    run_op("u55/0", 1'b0, 8'h55, 8'h00, {2'b01, 8'hFF, 8'h55}, 1'b0);
    run_op("s55/0", 1'b1, 8'h55, 8'h00, {2'b01, 8'hFF, 8'h55}, 1'b0);
    run_op("sAB/0", 1'b1, 8'hAB, 8'h00, {2'b01, 8'hFF, 8'hAB}, 1'b0);
    run_op("s80/FF", 1'b1, 8'h80, 8'hFF, {2'b10, 8'h80, 8'h00}, 1'b1);
    run_op("u80/FF", 1'b0, 8'h80, 8'hFF, {2'b00, 8'h00, 8'h80}, 1'b0);
    run_op("s80/01", 1'b1, 8'h80, 8'h01, {2'b00, 8'h80, 8'h00}, 1'b0);
    run_op("s80/7", 1'b1, 8'h80, 8'h07, {2'b00, 8'hEE, 8'hFE}, 1'b0);
    run_op("uFF/1", 1'b0, 8'hFF, 8'h01, {2'b00, 8'hFF, 8'h00}, 1'b0);

    // Back-to-back: start held high through the fix-up and done cycles.
    launch(1'b0, 8'd200, 8'd9, 1'b0);
    repeat (W) @(posedge clk);
    #1;
    signed_mode = 1'b1;
    dividend    = 8'h9C;
    divisor     = 8'h07;
    start       = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b first done", 32'(done), 32'd1);
    check_result("b2b first", {2'b00, 8'd22, 8'd2});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b accept busy", 32'(busy), 32'd1);
    chk("b2b accept done", 32'(done), 32'd0);
    finish_op("b2b second", {2'b00, 8'hF2, 8'hFE}, 1'b0);

    // Reset during an operation.
    launch(1'b0, 8'd250, 8'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset quotient", 32'(quotient), 32'd0);
    chk("midreset remainder", 32'(remainder), 32'd0);
    chk("midreset flags", 32'({div_by_zero, overflow}), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) saw_done = 1'b1;
    end
    chk("midreset no_done", 32'(saw_done), 32'd0);
    run_op("post_reset", 1'b1, 8'hC4, 8'h05, ref_div(1'b1, 8'hC4, 8'h05), 1'b0);

    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom);
      ra = pick();
      rb = pick();
      run_op($sformatf("rand%0d %s %02h/%02h", i, rm ? "s" : "u", ra, rb), rm, ra, rb,
             ref_div(rm, ra, rb), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
